// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the board-input conditioner: debounce state encodings,
// default filter length and a small width helper.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One-bit input filter: 2-flop synchroniser, stability counter and debounce FSM.
// INVERT flips an active-low input to active-high; PULSE_EN enables the press strobe.
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit INVERT   = 1'b0,
    parameter bit PULSE_EN = 1'b0,
    parameter int CNT_W    = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    logic [1:0]       sync;
    logic             active;
    logic [CNT_W-1:0] cnt;
    db_state_e        state;

    // Sync flops reset to the input's idle level so a released input never looks like a change.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync <= {2{INVERT}};
        end else begin
            sync <= {sync[0], raw};
        end
    end

    assign active = sync[1] ^ INVERT;

    // NOTE: every state, counter and output register updates with <= so all of them
    // see the values from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= DB_RELEASED;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            case (state)
                DB_RELEASED: begin
                    level <= 1'b0;
                    if (active) begin
                        if (CYCLES == 1) begin
                            state <= DB_PRESSED;
                            level <= 1'b1;
                            pulse <= PULSE_EN;
                            cnt   <= '0;
                        end else begin
                            state <= DB_PRESS_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!active) begin
                        state <= DB_RELEASED;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(CYCLES - 1)) begin
                        state <= DB_PRESSED;
                        level <= 1'b1;
                        pulse <= PULSE_EN;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DB_PRESSED: begin
                    level <= 1'b1;
                    if (!active) begin
                        if (CYCLES == 1) begin
                            state <= DB_RELEASED;
                            level <= 1'b0;
                            cnt   <= '0;
                        end else begin
                            state <= DB_RELEASE_WAIT;
                            cnt   <= CNT_W'(1);
                        end
                    end
                end
                DB_RELEASE_WAIT: begin
                    if (active) begin
                        state <= DB_PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_W'(CYCLES - 1)) begin
                        state <= DB_RELEASED;
                        level <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= DB_RELEASED;
                    level <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Board-input front end: debounces active-low push buttons into clean levels and press
// strobes, and filters slide switches into stable levels.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int N_BUTTONS        = 3,
    parameter int SW_WIDTH         = 15,
    parameter int DEBOUNCE_CYCLES  = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SW_STABLE_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_BUTTONS-1:0] button_raw,
    input  logic [SW_WIDTH-1:0]  switch_raw,
    output logic [N_BUTTONS-1:0] button_level,
    output logic [N_BUTTONS-1:0] button_pulse,
    output logic [SW_WIDTH-1:0]  switch_level
);

    localparam int CNT_W = $clog2(max_int(DEBOUNCE_CYCLES, SW_STABLE_CYCLES) + 1);

    // Switch channels never strobe; their pulse outputs are constant zero.
    logic [SW_WIDTH-1:0] switch_pulse_unused;

    for (genvar b = 0; b < N_BUTTONS; b++) begin : g_button
        debounce_channel #(
            .CYCLES  (DEBOUNCE_CYCLES),
            .INVERT  (1'b1),
            .PULSE_EN(1'b1),
            .CNT_W   (CNT_W)
        ) u_channel (
            .clk  (clk),
            .rst  (rst),
            .raw  (button_raw[b]),
            .level(button_level[b]),
            .pulse(button_pulse[b])
        );
    end

    for (genvar s = 0; s < SW_WIDTH; s++) begin : g_switch
        debounce_channel #(
            .CYCLES  (SW_STABLE_CYCLES),
            .INVERT  (1'b0),
            .PULSE_EN(1'b0),
            .CNT_W   (CNT_W)
        ) u_channel (
            .clk  (clk),
            .rst  (rst),
            .raw  (switch_raw[s]),
            .level(switch_level[s]),
            .pulse(switch_pulse_unused[s])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: expected press pulses are queued when buttons
// are driven and matched cycle-by-cycle against button_pulse.
module tb_input_conditioner;

    logic        clk;
    logic        rst;
    logic [2:0]  button_raw;
    logic [14:0] switch_raw;
    logic [2:0]  button_level;
    logic [2:0]  button_pulse;
    logic [14:0] switch_level;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit mon_en   = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [2:0] mon_want;

    input_conditioner #(
        .N_BUTTONS       (3),
        .SW_WIDTH        (15),
        .DEBOUNCE_CYCLES (4),
        .SW_STABLE_CYCLES(4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .button_raw  (button_raw),
        .switch_raw  (switch_raw),
        .button_level(button_level),
        .button_pulse(button_pulse),
        .switch_level(switch_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input int delay, input logic [2:0] val);
        exp_t e;
        e.cyc = cyc + delay;
        e.val = val;
        exp_q.push_back(e);
    endtask

    // Pulse scoreboard: every sampled cycle must show exactly the queued strobe, or none.
    always @(negedge clk) begin
        if (mon_en) begin
            mon_want = 3'b000;
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                mon_want = exp_q[0].val;
                void'(exp_q.pop_front());
            end
            check("pulse", 32'(button_pulse), 32'(mon_want));
        end
    end

    initial begin
        // 1. Reset sweep with random inputs
        rst        = 1'b0;
        button_raw = 3'($urandom_range(0, 7));
        switch_raw = 15'($urandom);
        tick(3);
        button_raw = 3'($urandom_range(0, 7));
        switch_raw = 15'($urandom);
        tick(2);
        check("rst_level", 32'(button_level), 32'h0);
        check("rst_pulse", 32'(button_pulse), 32'h0);
        check("rst_switch", 32'(switch_level), 32'h0);
        button_raw = 3'b111;
        switch_raw = 15'h0;
        tick(1);
        rst    = 1'b1;
        mon_en = 1'b1;
        tick(10);
        check("idle_level", 32'(button_level), 32'h0);
        check("idle_switch", 32'(switch_level), 32'h0);

        // 2. Clean press on button 0, held 20 cycles
        button_raw[0] = 1'b0;
        expect_pulse(6, 3'b001);
        tick(5);
        check("press0_early", 32'(button_level), 32'h0);
        tick(1);
        check("press0_level", 32'(button_level), 32'h1);
        tick(14);
        check("press0_held", 32'(button_level), 32'h1);
        button_raw[0] = 1'b1;
        tick(5);
        check("release0_early", 32'(button_level), 32'h1);
        tick(1);
        check("release0_level", 32'(button_level), 32'h0);
        tick(4);

        // 3. Bounce on button 1, then a settled fall
        for (int i = 0; i < 8; i++) begin
            button_raw[1] = i[0];
            tick(2);
        end
        check("bounce_level", 32'(button_level), 32'h0);
        button_raw[1] = 1'b0;
        expect_pulse(6, 3'b010);
        tick(5);
        check("bounce_early", 32'(button_level), 32'h0);
        tick(1);
        check("bounce_level_final", 32'(button_level), 32'h2);
        button_raw[1] = 1'b1;
        tick(8);
        check("bounce_release", 32'(button_level), 32'h0);

        // 4. Simultaneous press on all buttons
        button_raw = 3'b000;
        expect_pulse(6, 3'b111);
        tick(6);
        check("simul_level", 32'(button_level), 32'h7);
        tick(2);
        button_raw = 3'b111;
        tick(8);
        check("simul_release", 32'(button_level), 32'h0);

        // 5. Switch update and rejected glitch
        switch_raw = 15'h1A5C;
        tick(5);
        check("switch_early", 32'(switch_level), 32'h0);
        tick(1);
        check("switch_level", 32'(switch_level), 32'h1A5C);
        switch_raw = 15'h1A5C ^ 15'h0008;
        tick(2);
        switch_raw = 15'h1A5C;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("switch_glitch", 32'(switch_level), 32'h1A5C);
        end

        // 6. Reset mid-debounce, button held through reset release
        button_raw[2] = 1'b0;
        tick(4);
        rst = 1'b0;
        tick(3);
        check("middeb_rst_level", 32'(button_level), 32'h0);
        check("middeb_rst_switch", 32'(switch_level), 32'h0);
        rst = 1'b1;
        expect_pulse(6, 3'b100);
        tick(5);
        check("rehold_early", 32'(button_level), 32'h0);
        tick(1);
        check("rehold_level", 32'(button_level), 32'h4);
        button_raw[2] = 1'b1;
        tick(8);
        check("rehold_release", 32'(button_level), 32'h0);

        mon_en = 1'b0;
        check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
